// File: rtl/score_pkg.sv
// Shared types and helpers for the two-player score-bar controller.
// Covers the hit grades, the adder FSM states, the bitmap geometry and a single-digit BCD add.
package score_pkg;

    localparam int BAR_W = 55;
    localparam int BAR_H = 25;

    typedef enum logic [1:0] {
        G_NONE    = 2'b00,
        G_MISS    = 2'b01,
        G_GOOD    = 2'b10,
        G_PERFECT = 2'b11
    } grade_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_COMMIT
    } state_t;

    // Returns {carry_out, digit} for a + b + cin, where a and b are BCD digits.
    function automatic logic [4:0] bcd_inc(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > 5'd9) begin
            s    = s - 5'd10;
            s[4] = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/score_bar_pix.sv
// Pixel window test and label-bitmap lookup for both score bars.
// The pixel output is registered, so results appear one cycle after DrawX/DrawY.
module score_bar_pix
    import score_pkg::*;
#(
    parameter int BAR_X0_L = 16,
    parameter int BAR_X0_R = 560,
    parameter int BAR_Y0   = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [BAR_W*BAR_H-1:0]   bar_bits_l,
    input  logic [BAR_W*BAR_H-1:0]   bar_bits_r,
    output logic                     pix_on,
    output logic                     pix_side
);

    logic        w_in_y;
    logic        w_in_l;
    logic        w_in_r;
    logic [4:0]  w_row;
    logic [5:0]  w_col_l;
    logic [5:0]  w_col_r;
    logic [10:0] w_idx_l;
    logic [10:0] w_idx_r;

    assign w_in_y  = (DrawY >= 10'(BAR_Y0)) && (DrawY < 10'(BAR_Y0 + BAR_H));
    assign w_in_l  = w_in_y && (DrawX >= 10'(BAR_X0_L)) && (DrawX < 10'(BAR_X0_L + BAR_W));
    assign w_in_r  = w_in_y && (DrawX >= 10'(BAR_X0_R)) && (DrawX < 10'(BAR_X0_R + BAR_W));

    // Offsets are only meaningful inside a window, where they fit these narrow widths.
    assign w_row   = 5'(DrawY - 10'(BAR_Y0));
    assign w_col_l = 6'(DrawX - 10'(BAR_X0_L));
    assign w_col_r = 6'(DrawX - 10'(BAR_X0_R));
    assign w_idx_l = 11'(w_row) * 11'(BAR_W) + 11'(w_col_l);
    assign w_idx_r = 11'(w_row) * 11'(BAR_W) + 11'(w_col_r);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pix_on   <= 1'b0;
            pix_side <= 1'b0;
        end else begin
            assert (!(w_in_l && w_in_r));
            if (w_in_l) begin
                pix_on   <= bar_bits_l[w_idx_l];
                pix_side <= 1'b0;
            end else if (w_in_r) begin
                pix_on   <= bar_bits_r[w_idx_r];
                pix_side <= 1'b1;
            end else begin
                pix_on   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/score_bar_ctrl.sv
// Two-player scoring engine: per-side pending hits, a round-robin shared BCD ripple adder,
// combo counters, frame-latched display copies and the registered score-bar pixel lookup.
module score_bar_ctrl
    import score_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int PTS_PERFECT = 3,
    parameter int PTS_GOOD    = 1,
    parameter int BAR_X0_L    = 16,
    parameter int BAR_X0_R    = 560,
    parameter int BAR_Y0      = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_tick,
    input  logic [1:0]               hit_l,
    input  logic [1:0]               hit_r,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [BAR_W*BAR_H-1:0]   bar_bits_l,
    input  logic [BAR_W*BAR_H-1:0]   bar_bits_r,
    output logic [4*DIGITS-1:0]      score_l,
    output logic [4*DIGITS-1:0]      score_r,
    output logic [7:0]               combo_l,
    output logic [7:0]               combo_r,
    output logic                     busy,
    output logic                     drop_l,
    output logic                     drop_r,
    output logic                     pix_on,
    output logic                     pix_side
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_pend_l;
    logic                r_pend_r;
    grade_t              r_grade_l;
    grade_t              r_grade_r;
    logic                r_rr_last;
    logic                r_side;
    logic [4*DIGITS-1:0] r_work;
    logic [4*DIGITS-1:0] r_score_l;
    logic [4*DIGITS-1:0] r_score_r;
    logic [DW-1:0]       r_d;
    logic                r_carry;
    logic [3:0]          r_addend;
    logic [7:0]          r_combo_l;
    logic [7:0]          r_combo_r;

    grade_t              w_hit_l;
    grade_t              w_hit_r;
    grade_t              w_gnt_grade;
    logic                w_gnt_l;
    logic                w_gnt_r;
    logic                w_gnt_add;
    logic                w_rel_l;
    logic                w_rel_r;
    logic [3:0]          w_digit;
    logic [3:0]          w_add_in;
    logic [4:0]          w_sum;
    logic                w_last;
    logic                w_done;
    logic [4*DIGITS-1:0] w_work_nxt;

    // Saturating two-digit BCD increment; high digit cannot overflow once 99 is excluded.
    function automatic logic [7:0] combo_inc(input logic [7:0] c);
        logic [4:0] lo;
        if (c == 8'h99) return c;
        lo = bcd_inc(c[3:0], 4'd1, 1'b0);
        return {c[7:4] + {3'b000, lo[4]}, lo[3:0]};
    endfunction

    assign w_hit_l     = grade_t'(hit_l);
    assign w_hit_r     = grade_t'(hit_r);
    assign busy        = (r_state != S_IDLE);

    // rr_last = 1 means right was served last, so left wins a tie.
    assign w_gnt_l     = (r_state == S_IDLE) && r_pend_l && (!r_pend_r || r_rr_last);
    assign w_gnt_r     = (r_state == S_IDLE) && r_pend_r && (!r_pend_l || !r_rr_last);
    assign w_gnt_grade = w_gnt_r ? r_grade_r : r_grade_l;
    assign w_gnt_add   = (w_gnt_l || w_gnt_r) && (w_gnt_grade != G_MISS);
    assign w_rel_l     = (w_gnt_l && r_grade_l == G_MISS) || (r_state == S_COMMIT && !r_side);
    assign w_rel_r     = (w_gnt_r && r_grade_r == G_MISS) || (r_state == S_COMMIT &&  r_side);

    always_comb begin
        w_digit = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_d == DW'(i)) w_digit = r_work[4*i +: 4];
        end
    end

    assign w_add_in = (r_d == '0) ? r_addend : 4'd0;
    assign w_sum    = bcd_inc(w_digit, w_add_in, r_carry);
    assign w_last   = (r_d == DW'(DIGITS - 1));
    assign w_done   = w_last || (!w_sum[4] && r_d != '0);

    always_comb begin
        w_work_nxt = r_work;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_d == DW'(i)) w_work_nxt[4*i +: 4] = w_sum[3:0];
        end
        if (w_last && w_sum[4]) w_work_nxt = {DIGITS{4'h9}};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_gnt_add) w_state_nxt = S_ADD;
            S_ADD:    if (w_done)    w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rr_last <= 1'b1;
            r_side    <= 1'b0;
            r_work    <= '0;
            r_d       <= '0;
            r_carry   <= 1'b0;
            r_addend  <= '0;
            r_score_l <= '0;
            r_score_r <= '0;
        end else begin
            if (w_gnt_l || w_gnt_r) begin
                r_rr_last <= w_gnt_r;
                r_side    <= w_gnt_r;
                r_work    <= w_gnt_r ? r_score_r : r_score_l;
                r_addend  <= (w_gnt_grade == G_PERFECT) ? 4'(PTS_PERFECT) : 4'(PTS_GOOD);
                r_d       <= '0;
                r_carry   <= 1'b0;
            end
            if (r_state == S_ADD) begin
                r_work  <= w_work_nxt;
                r_d     <= r_d + DW'(1);
                r_carry <= w_sum[4];
            end
            if (r_state == S_COMMIT) begin
                if (r_side) r_score_r <= r_work;
                else        r_score_l <= r_work;
            end
        end
    end

    // A hit arriving while the slot is being released refills it instead of dropping.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pend_l  <= 1'b0;
            r_grade_l <= G_NONE;
            drop_l    <= 1'b0;
            r_combo_l <= '0;
        end else begin
            if (w_hit_l != G_NONE) begin
                if (r_pend_l && !w_rel_l) begin
                    drop_l <= 1'b1;
                end else begin
                    r_pend_l  <= 1'b1;
                    r_grade_l <= w_hit_l;
                end
            end else if (w_rel_l) begin
                r_pend_l <= 1'b0;
            end
            case (w_hit_l)
                G_MISS:            r_combo_l <= '0;
                G_GOOD, G_PERFECT: r_combo_l <= combo_inc(r_combo_l);
                default:           ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pend_r  <= 1'b0;
            r_grade_r <= G_NONE;
            drop_r    <= 1'b0;
            r_combo_r <= '0;
        end else begin
            if (w_hit_r != G_NONE) begin
                if (r_pend_r && !w_rel_r) begin
                    drop_r <= 1'b1;
                end else begin
                    r_pend_r  <= 1'b1;
                    r_grade_r <= w_hit_r;
                end
            end else if (w_rel_r) begin
                r_pend_r <= 1'b0;
            end
            case (w_hit_r)
                G_MISS:            r_combo_r <= '0;
                G_GOOD, G_PERFECT: r_combo_r <= combo_inc(r_combo_r);
                default:           ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            score_l <= '0;
            score_r <= '0;
            combo_l <= '0;
            combo_r <= '0;
        end else if (frame_tick) begin
            score_l <= r_score_l;
            score_r <= r_score_r;
            combo_l <= r_combo_l;
            combo_r <= r_combo_r;
        end
    end

    score_bar_pix #(
        .BAR_X0_L (BAR_X0_L),
        .BAR_X0_R (BAR_X0_R),
        .BAR_Y0   (BAR_Y0)
    ) u_pix (
        .Clk        (Clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .bar_bits_l (bar_bits_l),
        .bar_bits_r (bar_bits_r),
        .pix_on     (pix_on),
        .pix_side   (pix_side)
    );

endmodule

// File: tb/tb_score_bar_ctrl.sv
// Directed bench for score_bar_ctrl: a 6-digit instance for arbitration, ripple, drop, reset
// and pixel lookup, plus a 2-digit instance to reach score saturation and combo saturation.
module tb_score_bar_ctrl;

    logic          Clk;
    logic          Reset;
    logic          frame_tick;
    logic [1:0]    hit_l, hit_r, hit2_l, hit2_r;
    logic [9:0]    DrawX, DrawY;
    logic [1374:0] bar_bits_l, bar_bits_r;

    logic [23:0]   score_l, score_r;
    logic [7:0]    combo_l, combo_r;
    logic          busy, drop_l, drop_r, pix_on, pix_side;

    logic [7:0]    score2_l, score2_r;
    logic [7:0]    combo2_l, combo2_r;
    logic          busy2, drop2_l, drop2_r, pix2_on, pix2_side;

    int n_cmp = 0;
    int n_err = 0;

    score_bar_ctrl #(
        .DIGITS(6), .PTS_PERFECT(3), .PTS_GOOD(1),
        .BAR_X0_L(16), .BAR_X0_R(560), .BAR_Y0(8)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .hit_l(hit_l), .hit_r(hit_r), .DrawX(DrawX), .DrawY(DrawY),
        .bar_bits_l(bar_bits_l), .bar_bits_r(bar_bits_r),
        .score_l(score_l), .score_r(score_r), .combo_l(combo_l), .combo_r(combo_r),
        .busy(busy), .drop_l(drop_l), .drop_r(drop_r),
        .pix_on(pix_on), .pix_side(pix_side)
    );

    score_bar_ctrl #(
        .DIGITS(2)
    ) u_dut2 (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .hit_l(hit2_l), .hit_r(hit2_r), .DrawX(DrawX), .DrawY(DrawY),
        .bar_bits_l(bar_bits_l), .bar_bits_r(bar_bits_r),
        .score_l(score2_l), .score_r(score2_r), .combo_l(combo2_l), .combo_r(combo2_r),
        .busy(busy2), .drop_l(drop2_l), .drop_r(drop2_r),
        .pix_on(pix2_on), .pix_side(pix2_side)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    // Wait until the adder has stayed idle for two samples, so any queued grant has run.
    task automatic settle(input int which);
        int   idle_cnt;
        logic b;
        idle_cnt = 0;
        for (int n = 0; n < 40 && idle_cnt < 2; n++) begin
            tick();
            b = (which != 0) ? busy2 : busy;
            if (b) idle_cnt = 0;
            else   idle_cnt++;
        end
        chk("settle_idle", (which != 0) ? busy2 : busy, 1'b0);
    endtask

    task automatic wait_commit();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (busy) seen = 1'b1;
            else if (seen) break;
        end
        chk("commit_idle", busy, 1'b0);
    endtask

    task automatic issue(input int which, input logic [1:0] g);
        if (which != 0) hit2_l = g;
        else            hit_l  = g;
        tick();
        hit_l  = 2'b00;
        hit2_l = 2'b00;
        settle(which);
    endtask

    initial begin
        int n_busy;
        Reset = 1'b0; frame_tick = 1'b0;
        hit_l = 2'b00; hit_r = 2'b00; hit2_l = 2'b00; hit2_r = 2'b00;
        DrawX = 10'd0; DrawY = 10'd0;
        bar_bits_l = '0; bar_bits_r = '0;
        bar_bits_l[278] = 1'b1;
        bar_bits_r[0]   = 1'b1;
        repeat (3) tick();

        chk("rst_score_l", score_l, 24'h0);
        chk("rst_combo_l", combo_l, 8'h0);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_drop_l",  drop_l,  1'b0);
        chk("rst_pix_on",  pix_on,  1'b0);

        Reset = 1'b1;
        tick();

        // Simultaneous pair from reset: left first.
        hit_l = 2'b11; hit_r = 2'b10;
        tick();
        hit_l = 2'b00; hit_r = 2'b00;
        wait_commit();
        pulse_frame();
        chk("pair1_first_l", score_l, 24'h000003);
        chk("pair1_first_r", score_r, 24'h000000);
        chk("pair1_combo_l", combo_l, 8'h01);
        chk("pair1_combo_r", combo_r, 8'h01);
        settle(0);
        pulse_frame();
        chk("pair1_second_r", score_r, 24'h000001);

        // Lone left grant leaves left as last served; the next pair goes right first.
        issue(0, 2'b11);
        hit_l = 2'b11; hit_r = 2'b10;
        tick();
        hit_l = 2'b00; hit_r = 2'b00;
        wait_commit();
        pulse_frame();
        chk("pair2_first_r", score_r, 24'h000002);
        chk("pair2_first_l", score_l, 24'h000006);
        settle(0);
        pulse_frame();
        chk("pair2_second_l", score_l, 24'h000009);

        // Two left hits back to back while right is in the adder.
        hit_r = 2'b10;
        tick();
        hit_r = 2'b00;
        tick();
        hit_l = 2'b11;
        tick();
        tick();
        hit_l = 2'b00;
        settle(0);
        pulse_frame();
        chk("drop_l_set",   drop_l,  1'b1);
        chk("drop_r_clear", drop_r,  1'b0);
        chk("drop_score_l", score_l, 24'h000012);
        chk("drop_score_r", score_r, 24'h000003);

        // 12 + 29*3 = 99, then a good ripples over three digits.
        repeat (29) issue(0, 2'b11);
        pulse_frame();
        chk("pre_ripple", score_l, 24'h000099);
        hit_l = 2'b10;
        tick();
        hit_l = 2'b00;
        n_busy = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (busy) n_busy++;
            else if (n_busy > 0) break;
        end
        chk("ripple_cycles", n_busy, 4);
        chk("ripple_hidden", score_l, 24'h000099);
        pulse_frame();
        chk("ripple_result", score_l, 24'h000100);

        // 100 + 33*3 = 199; a good then carries into digit 2, where reset lands.
        repeat (33) issue(0, 2'b11);
        hit_l = 2'b10;
        tick();
        hit_l = 2'b00;
        tick();
        tick();
        tick();
        chk("midadd_busy", busy, 1'b1);
        Reset = 1'b0;
        #1;
        chk("rst2_score_l", score_l, 24'h0);
        chk("rst2_score_r", score_r, 24'h0);
        chk("rst2_combo_l", combo_l, 8'h0);
        chk("rst2_combo_r", combo_r, 8'h0);
        chk("rst2_busy",    busy,    1'b0);
        chk("rst2_drop_l",  drop_l,  1'b0);
        tick();
        Reset = 1'b1;
        tick();
        issue(0, 2'b11);
        pulse_frame();
        chk("post_rst_score", score_l, 24'h000003);

        // Pixel lookups.
        DrawX = 10'd19;  DrawY = 10'd13; tick();
        chk("pix_l_on",   pix_on,   1'b1);
        chk("pix_l_side", pix_side, 1'b0);
        DrawX = 10'd560; DrawY = 10'd8;  tick();
        chk("pix_r_on",   pix_on,   1'b1);
        chk("pix_r_side", pix_side, 1'b1);
        DrawX = 10'd71;  DrawY = 10'd13; tick();
        chk("pix_out_on",   pix_on,   1'b0);
        chk("pix_out_hold", pix_side, 1'b1);
        DrawX = 10'd18;  DrawY = 10'd13; tick();
        chk("pix_l_clear_on",   pix_on,   1'b0);
        chk("pix_l_clear_side", pix_side, 1'b0);
        DrawX = 10'd19;  DrawY = 10'd33; tick();
        chk("pix_below_on", pix_on, 1'b0);

        // Two-digit instance: 32*3 + 2*1 = 98, combo 34.
        repeat (32) issue(1, 2'b11);
        repeat (2)  issue(1, 2'b10);
        pulse_frame();
        chk("d2_score_98", score2_l, 8'h98);
        chk("d2_combo_34", combo2_l, 8'h34);
        issue(1, 2'b11);
        pulse_frame();
        chk("d2_score_sat", score2_l, 8'h99);
        repeat (64) issue(1, 2'b10);
        pulse_frame();
        chk("d2_combo_99", combo2_l, 8'h99);
        issue(1, 2'b10);
        pulse_frame();
        chk("d2_combo_sat", combo2_l, 8'h99);
        chk("d2_score_hold", score2_l, 8'h99);
        issue(1, 2'b01);
        pulse_frame();
        chk("d2_miss_combo", combo2_l, 8'h00);
        chk("d2_miss_score", score2_l, 8'h99);
        chk("d2_no_drop",    drop2_l,  1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
